// File: rtl/deparser_do_deparsing_pkg.sv
// Shared constants and types for the egress deparser.
//   - PHV container base offsets and widths, tenant id position
//   - Deparse action field positions and type encodings
//   - Action RAM geometry and control-stream beat field offsets
//   - FSM state types for the deparse and control-stream machines
package deparser_do_deparsing_pkg;

  // PHV layout
  localparam int PHV_6B_BASE   = 640;
  localparam int PHV_6B_W      = 48;
  localparam int PHV_4B_BASE   = 384;
  localparam int PHV_4B_W      = 32;
  localparam int PHV_2B_BASE   = 256;
  localparam int PHV_2B_W      = 16;
  localparam int PHV_VLAN_LSB  = 129;

  // Header
  localparam int HDR_BYTES     = 128;

  // Action word layout
  localparam int NUM_ACTS      = 10;
  localparam int ACT_W         = 16;
  localparam int ACT_EN_BIT    = 0;
  localparam int ACT_TYPE_LSB  = 1;
  localparam int ACT_IDX_LSB   = 3;
  localparam int ACT_OFF_LSB   = 6;

  typedef enum logic [1:0] {
    ACT_NONE = 2'b00,
    ACT_2B   = 2'b01,
    ACT_4B   = 2'b10,
    ACT_6B   = 2'b11
  } act_type_e;

  // Action RAM: 32 tenants, 10 actions each; address is vlan_id[8:4]
  localparam int ACT_RAM_W        = 160;
  localparam int ACT_RAM_AW       = 5;
  localparam int ACT_RAM_ADDR_LSB = 4;

  // Control-stream beat fields
  localparam int CTRL_MODID_LSB = 112;
  localparam int CTRL_ADDR_LSB  = 128;
  localparam int CTRL_DATA_BYTES = ACT_RAM_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RAM,
    ST_LOAD_SEGS,
    ST_APPLY,
    ST_OUTPUT
  } dep_state_e;

  typedef enum logic [2:0] {
    CT_BEAT1,
    CT_BEAT2,
    CT_BEAT3,
    CT_BEAT4,
    CT_FLUSH
  } ctrl_state_e;

  // Container width in bytes for an action type (0 for none).
  function automatic logic [2:0] act_bytes(input act_type_e t);
    case (t)
      ACT_2B:  act_bytes = 3'd2;
      ACT_4B:  act_bytes = 3'd4;
      ACT_6B:  act_bytes = 3'd6;
      default: act_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/deparser_do_deparsing_act_ram.sv
// Deparse action RAM: simple dual-port, one write port from the control
// stream, one registered read port for the deparse FSM. Read-first: a
// write to the address being read returns the old word on rd_data.
// Contents are not reset.
// Ports:
//   axis_clk        clock
//   wr_en/addr/data write port
//   rd_addr         read address, sampled every cycle
//   rd_data         registered read data (1-cycle latency)
module deparse_act_ram #(
  parameter int DW = 160,
  parameter int AW = 5
) (
  input  logic          axis_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge axis_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/deparser_do_deparsing.sv
// Egress deparser: writes each PHV container back into the original
// header segments at per-tenant byte offsets, then hands the rebuilt
// header and tuser to the output assembler. Actions are loaded over the
// in-band control stream, which is always forwarded with one cycle delay.
// Ports:
//   axis_clk, areset              clock, synchronous active-high reset
//   phv_in/valid_in/ready_out     PHV handshake
//   tdata_segs, segs_fifo_empty   head of original-header segment FIFO
//   segs_fifo_rd                  FIFO pop, one pulse per output handshake
//   deparsed_segs/tuser/valid     rebuilt header to assembler
//   deparsed_ready                downstream ready
//   ctrl_s_axis_*                 control stream in
//   ctrl_m_axis_*                 control stream out (registered copy)
//   pkt_cnt, skip_cnt             statistics, only with DEPARSER_STATS_EN
//
// Deparse FSM
//   state     | meaning
//   IDLE      | ready for a PHV; handshake latches it
//   WAIT_RAM  | action RAM read in flight
//   LOAD_SEGS | wait for segment FIFO, latch header and actions
//   APPLY     | apply one action per cycle, k = 0..9
//   OUTPUT    | result valid and stable until deparsed_ready
// Control FSM
//   state     | meaning
//   BEAT1     | first beat of a control packet (ignored)
//   BEAT2     | module id check, capture RAM address
//   BEAT3     | capture byte-reversed action word
//   BEAT4     | write the RAM
//   FLUSH     | drop beats until tlast
module deparser_do_deparsing
  import deparser_do_deparsing_pkg::*;
#(
  parameter int         C_AXIS_DATA_WIDTH  = 256,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter int         PKT_HDR_LEN        = 1024,
  parameter int         C_NUM_SEGS         = 4,
  parameter logic [2:0] DEPARSER_MOD_ID    = 3'd5,
  parameter int         C_VLANID_WIDTH     = 12
) (
  input  logic                                  axis_clk,
  input  logic                                  areset,
  input  logic [PKT_HDR_LEN-1:0]                phv_in,
  input  logic                                  phv_valid_in,
  output logic                                  phv_ready_out,
  input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
  input  logic                                  segs_fifo_empty,
  output logic                                  segs_fifo_rd,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] deparsed_segs,
  output logic [C_AXIS_TUSER_WIDTH-1:0]         deparsed_tuser,
  output logic                                  deparsed_valid,
  input  logic                                  deparsed_ready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]          ctrl_s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]         ctrl_s_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]        ctrl_s_axis_tkeep,
  input  logic                                  ctrl_s_axis_tvalid,
  input  logic                                  ctrl_s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]          ctrl_m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]         ctrl_m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]        ctrl_m_axis_tkeep,
  output logic                                  ctrl_m_axis_tvalid,
  output logic                                  ctrl_m_axis_tlast
`ifdef DEPARSER_STATS_EN
  ,
  output logic [31:0]                           pkt_cnt,
  output logic [31:0]                           skip_cnt
`endif
);

  localparam int SEGS_W = C_NUM_SEGS * C_AXIS_DATA_WIDTH;

  dep_state_e             state, state_nx;
  ctrl_state_e            cstate, cstate_nx;

  logic [PKT_HDR_LEN-1:0] phv_r;
  logic [ACT_RAM_W-1:0]   ram_rd_data;
  logic [ACT_RAM_W-1:0]   act_sh;
  logic [3:0]             act_cnt;
  logic                   phv_hs;

  logic [ACT_W-1:0]       cur_act;
  logic                   cur_en;
  act_type_e              cur_type;
  logic [2:0]             cur_idx;
  logic [6:0]             cur_off;
  logic [2:0]             cur_w;
  logic [47:0]            cur_val;
  logic                   cur_fits;
  logic                   cur_apply;
  logic                   cur_skip;
  logic [SEGS_W-1:0]      segs_applied;

  logic                   ctrl_mod_match;
  logic                   ram_wr_en;
  logic [ACT_RAM_AW-1:0]  ctrl_addr;
  logic [ACT_RAM_W-1:0]   ctrl_wdata;

  logic                   unused_bits;
  assign unused_bits = ^{phv_r[PKT_HDR_LEN-1:PHV_6B_BASE+8*PHV_6B_W],
                         phv_r[PHV_2B_BASE-1:PHV_VLAN_LSB+ACT_RAM_ADDR_LSB+ACT_RAM_AW],
                         phv_r[PHV_VLAN_LSB+ACT_RAM_ADDR_LSB-1:C_AXIS_TUSER_WIDTH],
                         cur_act[ACT_W-1:ACT_OFF_LSB+7]};

  // ---------------------------------------------------------------- deparse FSM
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state         <= ST_IDLE;
      phv_ready_out <= 1'b0;
    end else begin
      state         <= state_nx;
      phv_ready_out <= (state_nx == ST_IDLE);
    end
  end

  always_comb begin
    state_nx       = state;
    phv_hs         = 1'b0;
    deparsed_valid = 1'b0;
    segs_fifo_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        phv_hs = phv_valid_in && phv_ready_out;
        if (phv_hs) state_nx = ST_WAIT_RAM;
      end
      ST_WAIT_RAM:  state_nx = ST_LOAD_SEGS;
      ST_LOAD_SEGS: if (!segs_fifo_empty) state_nx = ST_APPLY;
      ST_APPLY:     if (act_cnt == 4'd0) state_nx = ST_OUTPUT;
      ST_OUTPUT: begin
        // gated by areset so a reset in OUTPUT never pops the FIFO
        deparsed_valid = !areset;
        segs_fifo_rd   = !areset && deparsed_ready;
        if (deparsed_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- action decode
  // Actions are consumed MSB-first: action k sits at the top of act_sh
  // after k shifts.
  assign cur_act  = act_sh[ACT_RAM_W-1 -: ACT_W];
  assign cur_en   = cur_act[ACT_EN_BIT];
  assign cur_type = act_type_e'(cur_act[ACT_TYPE_LSB +: 2]);
  assign cur_idx  = cur_act[ACT_IDX_LSB +: 3];
  assign cur_off  = cur_act[ACT_OFF_LSB +: 7];
  assign cur_w    = act_bytes(cur_type);

  // Container value left-aligned in 48 bits so its MSB byte is [47:40].
  always_comb begin
    cur_val = '0;
    case (cur_type)
      ACT_6B:  cur_val = phv_r[PHV_6B_BASE + PHV_6B_W*int'(cur_idx) +: 48];
      ACT_4B:  cur_val = {phv_r[PHV_4B_BASE + PHV_4B_W*int'(cur_idx) +: 32], 16'h0};
      ACT_2B:  cur_val = {phv_r[PHV_2B_BASE + PHV_2B_W*int'(cur_idx) +: 16], 32'h0};
      default: cur_val = '0;
    endcase
  end

  assign cur_fits  = ({1'b0, cur_off} + {5'b0, cur_w}) <= 8'(HDR_BYTES);
  assign cur_apply = cur_en && (cur_type != ACT_NONE) && cur_fits;
  assign cur_skip  = cur_en && !((cur_type != ACT_NONE) && cur_fits);

  // Byte b of the header takes container byte (b - off), MSB first.
  always_comb begin
    segs_applied = deparsed_segs;
    if (cur_apply) begin
      for (int b = 0; b < HDR_BYTES; b++) begin
        if (b >= int'(cur_off) && b < int'(cur_off) + int'(cur_w))
          segs_applied[8*b +: 8] = cur_val[8*(5 - (b - int'(cur_off))) +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      phv_r         <= '0;
      deparsed_segs <= '0;
      act_sh        <= '0;
      act_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (phv_hs) phv_r <= phv_in;
        ST_LOAD_SEGS: begin
          if (!segs_fifo_empty) begin
            deparsed_segs <= tdata_segs;
            act_sh        <= ram_rd_data;
            act_cnt       <= 4'(NUM_ACTS - 1);
          end
        end
        ST_APPLY: begin
          deparsed_segs <= segs_applied;
          act_sh        <= {act_sh[ACT_RAM_W-ACT_W-1:0], {ACT_W{1'b0}}};
          if (act_cnt != 4'd0) act_cnt <= act_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign deparsed_tuser = phv_r[C_AXIS_TUSER_WIDTH-1:0];

  deparse_act_ram #(
    .DW (ACT_RAM_W),
    .AW (ACT_RAM_AW)
  ) u_act_ram (
    .axis_clk (axis_clk),
    .wr_en    (ram_wr_en),
    .wr_addr  (ctrl_addr),
    .wr_data  (ctrl_wdata),
    .rd_addr  (phv_r[PHV_VLAN_LSB + ACT_RAM_ADDR_LSB +: ACT_RAM_AW]),
    .rd_data  (ram_rd_data)
  );

  // ---------------------------------------------------------------- control path
  assign ctrl_mod_match = (ctrl_s_axis_tdata[CTRL_MODID_LSB +: 3] == DEPARSER_MOD_ID);

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      cstate             <= CT_BEAT1;
      ctrl_addr          <= '0;
      ctrl_wdata         <= '0;
      ctrl_m_axis_tdata  <= '0;
      ctrl_m_axis_tuser  <= '0;
      ctrl_m_axis_tkeep  <= '0;
      ctrl_m_axis_tvalid <= 1'b0;
      ctrl_m_axis_tlast  <= 1'b0;
    end else begin
      cstate             <= cstate_nx;
      ctrl_m_axis_tdata  <= ctrl_s_axis_tdata;
      ctrl_m_axis_tuser  <= ctrl_s_axis_tuser;
      ctrl_m_axis_tkeep  <= ctrl_s_axis_tkeep;
      ctrl_m_axis_tvalid <= ctrl_s_axis_tvalid;
      ctrl_m_axis_tlast  <= ctrl_s_axis_tlast;
      if (ctrl_s_axis_tvalid && cstate == CT_BEAT2 && ctrl_mod_match)
        ctrl_addr <= ctrl_s_axis_tdata[CTRL_ADDR_LSB +: ACT_RAM_AW];
      // tdata byte 0 becomes the most significant byte of the action word
      if (ctrl_s_axis_tvalid && cstate == CT_BEAT3)
        for (int i = 0; i < CTRL_DATA_BYTES; i++)
          ctrl_wdata[ACT_RAM_W-1-8*i -: 8] <= ctrl_s_axis_tdata[8*i +: 8];
    end
  end

  always_comb begin
    cstate_nx = cstate;
    ram_wr_en = 1'b0;
    if (ctrl_s_axis_tvalid) begin
      case (cstate)
        CT_BEAT1: cstate_nx = ctrl_s_axis_tlast ? CT_BEAT1 : CT_BEAT2;
        CT_BEAT2: begin
          if (ctrl_s_axis_tlast)   cstate_nx = CT_BEAT1;
          else if (ctrl_mod_match) cstate_nx = CT_BEAT3;
          else                     cstate_nx = CT_FLUSH;
        end
        CT_BEAT3: cstate_nx = ctrl_s_axis_tlast ? CT_BEAT1 : CT_BEAT4;
        CT_BEAT4: begin
          ram_wr_en = 1'b1;
          cstate_nx = ctrl_s_axis_tlast ? CT_BEAT1 : CT_FLUSH;
        end
        CT_FLUSH: if (ctrl_s_axis_tlast) cstate_nx = CT_BEAT1;
        default:  cstate_nx = CT_BEAT1;
      endcase
    end
  end

`ifdef DEPARSER_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      pkt_cnt  <= '0;
      skip_cnt <= '0;
    end else begin
      if (segs_fifo_rd) pkt_cnt <= pkt_cnt + 32'd1;
      if (state == ST_APPLY && cur_skip) skip_cnt <= skip_cnt + 32'd1;
    end
  end
`else
  logic unused_skip;
  assign unused_skip = cur_skip;
`endif

endmodule

// File: tb/tb_deparser_do_deparsing.sv
module tb_deparser_do_deparsing;

  logic          axis_clk = 1'b0;
  logic          areset;
  logic [1023:0] phv_in;
  logic          phv_valid_in;
  logic          phv_ready_out;
  logic [1023:0] tdata_segs;
  logic          segs_fifo_empty;
  logic          segs_fifo_rd;
  logic [1023:0] deparsed_segs;
  logic [127:0]  deparsed_tuser;
  logic          deparsed_valid;
  logic          deparsed_ready;
  logic [255:0]  ctrl_s_axis_tdata;
  logic [127:0]  ctrl_s_axis_tuser;
  logic [31:0]   ctrl_s_axis_tkeep;
  logic          ctrl_s_axis_tvalid;
  logic          ctrl_s_axis_tlast;
  logic [255:0]  ctrl_m_axis_tdata;
  logic [127:0]  ctrl_m_axis_tuser;
  logic [31:0]   ctrl_m_axis_tkeep;
  logic          ctrl_m_axis_tvalid;
  logic          ctrl_m_axis_tlast;
`ifdef DEPARSER_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [31:0]   skip_cnt;
`endif

  always #5 axis_clk = ~axis_clk;

  deparser_do_deparsing dut (
    .axis_clk           (axis_clk),
    .areset             (areset),
    .phv_in             (phv_in),
    .phv_valid_in       (phv_valid_in),
    .phv_ready_out      (phv_ready_out),
    .tdata_segs         (tdata_segs),
    .segs_fifo_empty    (segs_fifo_empty),
    .segs_fifo_rd       (segs_fifo_rd),
    .deparsed_segs      (deparsed_segs),
    .deparsed_tuser     (deparsed_tuser),
    .deparsed_valid     (deparsed_valid),
    .deparsed_ready     (deparsed_ready),
    .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
    .ctrl_s_axis_tuser  (ctrl_s_axis_tuser),
    .ctrl_s_axis_tkeep  (ctrl_s_axis_tkeep),
    .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
    .ctrl_s_axis_tlast  (ctrl_s_axis_tlast),
    .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
    .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
    .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
    .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
    .ctrl_m_axis_tlast  (ctrl_m_axis_tlast)
`ifdef DEPARSER_STATS_EN
    ,
    .pkt_cnt            (pkt_cnt),
    .skip_cnt           (skip_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pkt_m  = 0;
  int skip_m = 0;
  logic [159:0] ram_m [32];

  always @(posedge axis_clk) if (segs_fifo_rd === 1'b1) pops++;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 4; i++) r[256*i +: 256] = rand256();
    return r;
  endfunction

  function automatic logic [15:0] mk_act(input logic en, input logic [1:0] t,
                                         input logic [2:0] idx, input logic [6:0] off);
    return {3'b000, off, idx, t, en};
  endfunction

  // Reference: header as a byte array, containers copied MSB-first.
  function automatic logic [1023:0] model_hdr(input logic [1023:0] phv, input logic [1023:0] segs,
                                              input logic [159:0] word, output int skips);
    logic [7:0]    hdr [128];
    logic [15:0]   a;
    logic [1023:0] res;
    int w, off, base;
    skips = 0;
    for (int b = 0; b < 128; b++) hdr[b] = segs[8*b +: 8];
    for (int k = 0; k < 10; k++) begin
      a   = word[144 - 16*k +: 16];
      off = int'(a[12:6]);
      case (a[2:1])
        2'b01:   begin w = 2; base = 256 + 16*int'(a[5:3]); end
        2'b10:   begin w = 4; base = 384 + 32*int'(a[5:3]); end
        2'b11:   begin w = 6; base = 640 + 48*int'(a[5:3]); end
        default: begin w = 0; base = 0; end
      endcase
      if (a[0]) begin
        if (w == 0 || off + w > 128) skips++;
        else for (int j = 0; j < w; j++) hdr[off + j] = phv[base + 8*(w - 1 - j) +: 8];
      end
    end
    for (int b = 0; b < 128; b++) res[8*b +: 8] = hdr[b];
    return res;
  endfunction

  task automatic ctrl_write(input logic [4:0] addr, input logic [2:0] mod, input logic [159:0] word);
    logic [255:0] d [4];
    logic [417:0] fwd;
    for (int b = 0; b < 4; b++) d[b] = rand256();
    d[1][119:112] = {5'($urandom), mod};
    d[1][135:128] = {3'($urandom), addr};
    for (int i = 0; i < 20; i++) d[2][8*i +: 8] = word[159 - 8*i -: 8];
    for (int b = 0; b < 4; b++) begin
      ctrl_s_axis_tdata  = d[b];
      ctrl_s_axis_tuser  = {rand256()}[127:0];
      ctrl_s_axis_tkeep  = $urandom;
      ctrl_s_axis_tvalid = 1'b1;
      ctrl_s_axis_tlast  = (b == 3);
      fwd = {ctrl_s_axis_tdata, ctrl_s_axis_tuser, ctrl_s_axis_tkeep, 1'b1, ctrl_s_axis_tlast};
      step();
      check_val("ctrl_fwd", 512'({ctrl_m_axis_tdata, ctrl_m_axis_tuser, ctrl_m_axis_tkeep,
                                  ctrl_m_axis_tvalid, ctrl_m_axis_tlast}), 512'(fwd));
    end
    ctrl_s_axis_tvalid = 1'b0;
    ctrl_s_axis_tlast  = 1'b0;
    step();
    check_val("ctrl_fwd_idle", 512'(ctrl_m_axis_tvalid), 512'(0));
    if (mod == 3'd5) ram_m[addr] = word;
  endtask

  task automatic run_pkt(input logic [1023:0] phv, input logic [1023:0] segs,
                         input int stall, input int rdly, output logic [1023:0] got);
    logic [1023:0] exp;
    int sk, cyc, p0, n;
    exp = model_hdr(phv, segs, ram_m[phv[137:133]], sk);
    n = 0;
    while (!phv_ready_out && n < 50) begin step(); n++; end
    if (!phv_ready_out) check_val("ready_timeout", 512'(0), 512'(1));
    p0 = pops;
    phv_in          = phv;
    phv_valid_in    = 1'b1;
    tdata_segs      = segs;
    segs_fifo_empty = (stall > 0);
    step();
    cyc = 1;
    phv_valid_in = 1'b0;
    phv_in       = rand1024();
    check_val("busy_not_ready", 512'(phv_ready_out), 512'(0));
    while (!deparsed_valid && cyc < 100) begin
      segs_fifo_empty = (stall > 0) && (cyc < 2 + stall);
      step();
      cyc++;
    end
    segs_fifo_empty = 1'b0;
    check_val("latency", 512'(cyc), 512'(13 + stall));
    check_val("no_early_pop", 512'(pops), 512'(p0));
    check_val("segs_lo", deparsed_segs[511:0], exp[511:0]);
    check_val("segs_hi", deparsed_segs[1023:512], exp[1023:512]);
    check_val("tuser", 512'(deparsed_tuser), 512'(phv[127:0]));
    got = deparsed_segs;
    for (int i = 0; i < rdly; i++) begin
      step();
      check_val("hold_valid", 512'(deparsed_valid), 512'(1));
      check_val("hold_segs", deparsed_segs[511:0], exp[511:0]);
    end
    deparsed_ready = 1'b1;
    step();
    deparsed_ready = 1'b0;
    check_val("one_pop", 512'(pops), 512'(p0 + 1));
    check_val("valid_drop", 512'(deparsed_valid), 512'(0));
    skip_m += sk;
    pkt_m++;
  endtask

  function automatic logic [1023:0] mk_phv(input logic [4:0] addr);
    logic [1023:0] p;
    p = rand1024();
    p[140:129] = {3'($urandom), addr, 4'($urandom)};
    return p;
  endfunction

  initial begin
    logic [159:0]  w;
    logic [1023:0] phv, segs, got;
    int p0;

    areset = 1'b1;
    phv_in = '0; phv_valid_in = 1'b0; tdata_segs = '0; segs_fifo_empty = 1'b1;
    deparsed_ready = 1'b0;
    ctrl_s_axis_tdata = '0; ctrl_s_axis_tuser = '0; ctrl_s_axis_tkeep = '0;
    ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tlast = 1'b0;
    repeat (3) step();
    check_val("rst_ready", 512'(phv_ready_out), 512'(0));
    check_val("rst_valid", 512'(deparsed_valid), 512'(0));
    check_val("rst_rd", 512'(segs_fifo_rd), 512'(0));
    check_val("rst_segs", deparsed_segs[511:0], 512'(0));
    check_val("rst_tuser", 512'(deparsed_tuser), 512'(0));
    check_val("rst_ctrl_valid", 512'(ctrl_m_axis_tvalid), 512'(0));
    areset = 1'b0;
    segs_fifo_empty = 1'b0;
    step();
    check_val("ready_after_rst", 512'(phv_ready_out), 512'(1));

    // 6B container at offset 0
    w = '0; w[159:144] = mk_act(1'b1, 2'b11, 3'd0, 7'd0);
    ctrl_write(5'd1, 3'd5, w);
    phv = mk_phv(5'd1); phv[640 +: 48] = 48'h112233445566;
    segs = rand1024();
    run_pkt(phv, segs, 0, 0, got);
    check_val("6b_bytes", 512'(got[47:0]), 512'(48'h665544332211));
    check_val("6b_rest", 512'(got[1023:48] == segs[1023:48]), 512'(1));

    // 4B at offset 126 runs past the header end
    w = '0; w[159:144] = mk_act(1'b1, 2'b10, 3'd2, 7'd126);
    ctrl_write(5'd2, 3'd5, w);
    segs = rand1024();
    run_pkt(mk_phv(5'd2), segs, 0, 0, got);
    check_val("oob_untouched", 512'(got == segs), 512'(1));

    // overlapping actions 2 and 7, later wins
    w = '0;
    w[144 - 16*2 +: 16] = mk_act(1'b1, 2'b01, 3'd0, 7'd12);
    w[144 - 16*7 +: 16] = mk_act(1'b1, 2'b01, 3'd1, 7'd12);
    ctrl_write(5'd4, 3'd5, w);
    phv = mk_phv(5'd4); phv[256 +: 16] = 16'hAAAA; phv[272 +: 16] = 16'hBBBB;
    run_pkt(phv, rand1024(), 0, 0, got);
    check_val("overlap", 512'(got[96 +: 16]), 512'(16'hBBBB));

    // FIFO stall and downstream backpressure
    run_pkt(mk_phv(5'd1), rand1024(), 5, 3, got);

    // control write to addr 3, then a rejected write with the wrong module id
    w = '0; w[159:144] = mk_act(1'b1, 2'b10, 3'd5, 7'd40);
    w[15:0] = mk_act(1'b1, 2'b11, 3'd7, 7'd100);
    ctrl_write(5'd3, 3'd5, w);
    phv = rand1024(); phv[140:129] = 12'h030;
    run_pkt(phv, rand1024(), 0, 1, got);
    w = '0; w[159:144] = mk_act(1'b1, 2'b01, 3'd1, 7'd0);
    ctrl_write(5'd3, 3'd2, w);
    phv = rand1024(); phv[140:129] = 12'h030;
    run_pkt(phv, rand1024(), 0, 0, got);

    // reset in the middle of APPLY
    p0 = pops;
    phv_in = mk_phv(5'd1); phv_valid_in = 1'b1; tdata_segs = rand1024();
    step();
    phv_valid_in = 1'b0;
    repeat (5) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    check_val("midrst_valid", 512'(deparsed_valid), 512'(0));
    step();
    check_val("midrst_ready", 512'(phv_ready_out), 512'(1));
    deparsed_ready = 1'b1;
    repeat (15) begin
      step();
      check_val("midrst_no_valid", 512'(deparsed_valid), 512'(0));
    end
    deparsed_ready = 1'b0;
    check_val("midrst_no_pop", 512'(pops), 512'(p0));
    pkt_m = 0; skip_m = 0;

    // randomized tenants and actions
    for (int n = 0; n < 14; n++) begin
      logic [4:0] a;
      logic [6:0] off;
      a = 5'($urandom);
      for (int k = 0; k < 10; k++) begin
        off = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom);
        w[144 - 16*k +: 16] = {3'($urandom), off, 3'($urandom), 2'($urandom),
                               1'($urandom_range(0, 3) != 0)};
      end
      ctrl_write(a, ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd5, w);
      if (n < 2) run_pkt(mk_phv(a), rand1024(), 0, 0, got);
      else run_pkt(mk_phv(a), rand1024(), $urandom_range(0, 3), $urandom_range(0, 2), got);
    end

`ifdef DEPARSER_STATS_EN
    check_val("pkt_cnt", 512'(pkt_cnt), 512'(pkt_m));
    check_val("skip_cnt", 512'(skip_cnt), 512'(skip_m));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
